ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/loader_pkg.sv | 23 ++
 rtl/ram_loader_if.sv | 26 ++
 rtl/ram_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the RAM loader: FSM state encoding,
// default frame marker and the checksum accumulate helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    REPORT
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Modulo-256 running sum of payload bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input plus RAM write port and status pins of the loader.
// The master side feeds frame bytes; the slave side is the loader itself.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_data;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_cs, ram_we, ram_addr, ram_data, cpu_hold, load_done, load_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_cs, ram_we, ram_addr, ram_data, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/ram_loader.sv
// Parses SYNC/addr/len/payload/csum frames from a byte stream and writes the
// payload into RAM through a registered write port, reporting checksum status.
module ram_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_loader_if.slave   bus
);

  state_t                state_q;
  logic [7:0]            addr_hi_q;
  logic [7:0]            len_hi_q;
  logic [15:0]           len_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            sum_q;
  logic                  in_ready_q;
  logic                  ram_cs_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [7:0]            ram_data_q;
  logic                  cpu_hold_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [7:0]            sum_d;
  logic [15:0]           len_d;

  assign accept    = bus.in_valid && in_ready_q;
  assign wr_addr_d = wr_addr_q + 1'b1;
  assign sum_d     = csum_add(sum_q, bus.in_data);
  assign len_d     = {len_hi_q, bus.in_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_hi_q   <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      wr_addr_q   <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      // Strobes and status are single-cycle unless re-armed below.
      in_ready_q  <= 1'b1;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      case (state_q)
        IDLE: if (accept && bus.in_data == SYNC_BYTE) begin
          state_q    <= ADDR_HI;
          cpu_hold_q <= 1'b1;
          sum_q      <= '0;
        end
        ADDR_HI: if (accept) begin
          addr_hi_q <= bus.in_data;
          state_q   <= ADDR_LO;
        end
        ADDR_LO: if (accept) begin
          wr_addr_q <= ADDR_WIDTH'({addr_hi_q, bus.in_data});
          state_q   <= LEN_HI;
        end
        LEN_HI: if (accept) begin
          len_hi_q <= bus.in_data;
          state_q  <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          len_q   <= len_d;
          state_q <= (len_d == 16'd0) ? CSUM : DATA;
        end
        DATA: if (accept) begin
          ram_cs_q   <= 1'b1;
          ram_we_q   <= 1'b1;
          ram_addr_q <= wr_addr_q;
          ram_data_q <= bus.in_data;
          wr_addr_q  <= wr_addr_d;
          sum_q      <= sum_d;
          len_q      <= len_q - 16'd1;
          if (len_q == 16'd1) state_q <= CSUM;
        end
        CSUM: if (accept) begin
          load_done_q <= (bus.in_data == sum_q);
          load_err_q  <= (bus.in_data != sum_q);
          in_ready_q  <= 1'b0;
          state_q     <= REPORT;
        end
        REPORT: begin
          cpu_hold_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule
